// File: rtl/control_divisor.sv
// Programmable tick / clk_out generator with start/stop sequencing, finite bursts and
// glitch-free reconfiguration at period boundaries. Optional pause: define CTRL_PAUSE_EN.
module control_divisor #(
    parameter int          CW          = 26,
    parameter int          BW          = 16,
    parameter int unsigned DEFAULT_DIV = 4999
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_divisor,
    input  logic [BW-1:0] cfg_burst,
    input  logic          start,
    input  logic          stop,
`ifdef CTRL_PAUSE_EN
    input  logic          pause,
`endif
    output logic          tick,
    output logic          clk_out,
    output logic          busy,
    output logic          done,
    output logic          cfg_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] div_q;
    logic [CW-1:0] div_sh;
    logic [BW-1:0] bcnt;
    logic [BW-1:0] burst_q;
    logic [BW-1:0] burst_sh;
    logic          pend_v;
    logic          hold;
    logic          xfer;
    logic          cfg_ok;

`ifdef CTRL_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    // Config handshake: a word transfers on any edge where cfg_valid && cfg_ready;
    // cfg_ready only drops while a shadowed word waits for a period boundary.
    assign cfg_ready = !pend_v;
    assign xfer      = cfg_valid && cfg_ready;
    assign cfg_ok    = xfer && (cfg_divisor != '0);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bcnt     <= '0;
            div_q    <= CW'(DEFAULT_DIV);
            burst_q  <= '0;
            div_sh   <= '0;
            burst_sh <= '0;
            pend_v   <= 1'b0;
            tick     <= 1'b0;
            clk_out  <= 1'b0;
            done     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            tick    <= 1'b0;
            done    <= 1'b0;
            cfg_err <= xfer && (cfg_divisor == '0);
            if (state == IDLE) begin
                if (start && !stop) begin
                    state <= RUN;
                    cnt   <= '0;
                    bcnt  <= burst_q;
                end
                if (cfg_ok) begin
                    div_q   <= cfg_divisor;
                    burst_q <= cfg_burst;
                end
            end else if (stop) begin
                state   <= IDLE;
                cnt     <= '0;
                clk_out <= 1'b0;
                if (pend_v) begin
                    div_q   <= div_sh;
                    burst_q <= burst_sh;
                    pend_v  <= 1'b0;
                end
                if (cfg_ok) begin
                    div_q   <= cfg_divisor;
                    burst_q <= cfg_burst;
                end
            end else if (hold) begin
                state <= PAUSE;
                if (cfg_ok) begin
                    div_sh   <= cfg_divisor;
                    burst_sh <= cfg_burst;
                    pend_v   <= 1'b1;
                end
            end else begin
                state <= RUN;
                if (cnt == div_q) begin
                    cnt  <= '0;
                    tick <= 1'b1;
                    // bcnt==0 marks a continuous run; a finite burst never reaches 0 in RUN
                    if (bcnt == BW'(1)) begin
                        bcnt    <= '0;
                        done    <= 1'b1;
                        state   <= IDLE;
                        clk_out <= 1'b0;
                    end else begin
                        clk_out <= ~clk_out;
                        if (bcnt != '0) begin
                            bcnt <= bcnt - BW'(1);
                        end
                    end
                    if (pend_v) begin
                        div_q   <= div_sh;
                        burst_q <= burst_sh;
                        pend_v  <= 1'b0;
                    end
                    if (cfg_ok) begin
                        div_q   <= cfg_divisor;
                        burst_q <= cfg_burst;
                    end
                end else begin
                    cnt <= cnt + CW'(1);
                    if (cfg_ok) begin
                        div_sh   <= cfg_divisor;
                        burst_sh <= cfg_burst;
                        pend_v   <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
